// File: rtl/snn_pkg.sv
// Shared spiking-network constants and the current saturation helper.
package snn_pkg;

  localparam int WEIGHT_W    = 8;
  localparam int CURRENT_W   = 8;
  localparam int SUM_W       = 12;
  localparam int CURRENT_MAX = 127;
  localparam int CURRENT_MIN = -128;

  // Clamp a wide signed sum into the neuron current range instead of wrapping.
  function automatic logic signed [CURRENT_W-1:0] saturate(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] max_v;
    logic signed [SUM_W-1:0] min_v;
    max_v = SUM_W'(CURRENT_MAX);
    min_v = SUM_W'(CURRENT_MIN);
    if (sum > max_v) begin
      return max_v[CURRENT_W-1:0];
    end else if (sum < min_v) begin
      return min_v[CURRENT_W-1:0];
    end
    return sum[CURRENT_W-1:0];
  endfunction

endpackage

// File: rtl/delayed_synapse_integrator_if.sv
// Bus between the network controller and the delayed synapse integrator.
interface delayed_synapse_integrator_if
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DELAY_W    = 2
);

  // current_valid qualifies input_current/arrivals for exactly one cycle per
  // enabled step; there is no ready, so the consumer must take it that cycle.
  logic                            enable;
  logic                            clear;
  logic [NUM_INPUTS-1:0]           spikes_in;
  logic [WEIGHT_W*NUM_INPUTS-1:0]  weights;
  logic [DELAY_W*NUM_INPUTS-1:0]   delays;
  logic [CURRENT_W-1:0]            input_current;
  logic                            current_valid;
  logic [NUM_INPUTS-1:0]           arrivals;

  modport master (
    output enable, clear, spikes_in, weights, delays,
    input  input_current, current_valid, arrivals
  );

  modport slave (
    input  enable, clear, spikes_in, weights, delays,
    output input_current, current_valid, arrivals
  );

endinterface

// File: rtl/synapse_delay_line.sv
// One synapse: pending-spike slots (slot k = arrives k steps from now) and
// the combinational arrival bit for the current step.
module synapse_delay_line #(
  parameter int DELAY_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               spike,
  input  logic [DELAY_W-1:0] delay,
  output logic               arrival
);

  localparam int MAX_DELAY = (1 << DELAY_W) - 1;

  logic [MAX_DELAY:1] slots;
  logic [MAX_DELAY:1] slots_nxt;

  assign arrival = ((delay == '0) && spike) || slots[1];

  // Shift toward slot 1, then OR in the new spike so collisions merge.
  always_comb begin
    slots_nxt = slots >> 1;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (spike && (delay == DELAY_W'(k))) begin
        slots_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      slots <= '0;
    end else if (enable) begin
      slots <= slots_nxt;
    end
  end

endmodule

// File: rtl/delayed_synapse_integrator.sv
// Per-synapse delay lines feeding a saturated weighted sum that becomes the
// neuron's input current, registered once per enabled time step.
module delayed_synapse_integrator
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DELAY_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  delayed_synapse_integrator_if.slave  bus
);

  logic [NUM_INPUTS-1:0]          arrival_vec;
  logic signed [SUM_W-1:0]        sum;
  logic signed [CURRENT_W-1:0]    current_q;
  logic [NUM_INPUTS-1:0]          arrivals_q;
  logic                           valid_q;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_syn
    synapse_delay_line #(
      .DELAY_W (DELAY_W)
    ) u_line (
      .clk     (clk),
      .reset   (reset),
      .enable  (bus.enable),
      .clear   (bus.clear),
      .spike   (bus.spikes_in[i]),
      .delay   (bus.delays[DELAY_W*i +: DELAY_W]),
      .arrival (arrival_vec[i])
    );
  end

  // SUM_W is wide enough for NUM_INPUTS <= 8 full-scale weights.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (arrival_vec[i]) begin
        sum = sum + SUM_W'(signed'(bus.weights[WEIGHT_W*i +: WEIGHT_W]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_q  <= '0;
      arrivals_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.clear) begin
      valid_q <= 1'b0;
      if (bus.enable) begin
        current_q  <= '0;
        arrivals_q <= '0;
      end
    end else if (bus.enable) begin
      current_q  <= saturate(sum);
      arrivals_q <= arrival_vec;
      valid_q    <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.input_current = current_q;
  assign bus.arrivals      = arrivals_q;
  assign bus.current_valid = valid_q;

endmodule

// File: doc/delayed_synapse_integrator.md
DELAYED_SYNAPSE_INTEGRATOR -- requirements
Module: delayed_synapse_integrator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of presynaptic inputs (legal range 1..8).
REQ-002 SHALL have parameter DELAY_W, default 2, width of each per-synapse delay; MAX_DELAY = 2^DELAY_W - 1.
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 enable  input  1  network time-step strobe; state advances only on cycles with enable=1.
REQ-007 clear  input  1  synchronous flush of all pending delayed spikes.
REQ-008 spikes_in  input  NUM_INPUTS  presynaptic spikes, sampled only when enable=1.
REQ-009 weights  input  8*NUM_INPUTS  signed two's-complement weight per synapse; synapse i at bits [8i+7:8i].
REQ-010 delays  input  DELAY_W*NUM_INPUTS  per-synapse delay in time steps; synapse i at bits [DELAY_W*i+DELAY_W-1:DELAY_W*i].
REQ-011 input_current  output  8  registered signed saturated weighted sum; drives the neuron's input current.
REQ-012 current_valid  output  1  one-cycle pulse marking a new input_current value.
REQ-013 arrivals  output  NUM_INPUTS  registered per-synapse arrival vector for the step (debug).

Function
REQ-014 A spike on spikes_in[i] sampled at time step t with delay d SHALL arrive at step t+d; d=0 arrives in the same step.
REQ-015 Each synapse SHALL hold a MAX_DELAY-slot pending register; slot k means "arrives k steps from now".
REQ-016 On an enable cycle: arrival[i] = (d==0 & spikes_in[i]) | slot1[i]; slots shift down one (slot k <- slot k+1, top slot <- 0); if d>0 and spikes_in[i]=1, slot d is additionally set.
REQ-017 Collision (new spike targets a slot already set, e.g. after a delay change) SHALL merge by OR; it counts as one arrival.
REQ-018 Delay is sampled with each spike; changing delays SHALL NOT move spikes already pending.
REQ-019 Sum SHALL be the signed sum of weights[i] over all i with arrival[i]=1, computed at 12-bit signed width without overflow.
REQ-020 input_current SHALL be the sum clamped to [-128, +127] (saturate to 8'h80 / 8'h7F), never wrapped.
REQ-021 input_current, arrivals and current_valid=1 SHALL be registered on the clock edge ending the enable cycle (latency 1 clk from enable).
REQ-022 On cycles with enable=0: no slot changes, current_valid=0, input_current and arrivals hold their last value.
REQ-023 A step with no arrivals SHALL still pulse current_valid with input_current=0 and arrivals=0.
REQ-024 clear=1 SHALL zero all slots on that edge; if enable=1 same cycle, clear wins: no arrival computed, current_valid=0, input_current=0, arrivals=0.
REQ-025 Back-to-back enable cycles SHALL each produce a valid step with no bubble.

Reset
REQ-026 reset SHALL take priority over clear and enable.
REQ-027 On reset: all slots=0, input_current=8'h00, arrivals=0, current_valid=0.
REQ-028 First post-reset enable SHALL behave as step 0 with no pending spikes; no spike sampled during reset is retained.

Structure
REQ-029 Shared package snn_pkg SHALL hold WEIGHT_W=8, CURRENT_W=8, SUM_W=12, CURRENT_MAX=127, CURRENT_MIN=-128 and the saturation function.
REQ-030 One sub-module synapse_delay_line SHALL implement a single synapse's slots and arrival bit, instantiated NUM_INPUTS times.
REQ-031 The weighted sum and saturation SHALL be in the top module; all outputs registered.

Verification
REQ-032 Delay 0, weights {10,20,30,40}, spikes_in=4'b0101 on one enable -> next clk input_current=40, arrivals=0101, valid pulse 1 clk.
REQ-033 Synapse 0 delay=3, weight=5, spike at step 0, enables every cycle -> input_current=0 steps 0-2, =5 at step 3, 0 at step 4.
REQ-034 All four weights=100, all delays 0, spikes=1111 -> input_current=127; all weights=-100 -> -128.
REQ-035 Synapse 1 delay=2 spike at step 0, delay changed to 1 and spike at step 1 -> single arrival at step 2 (merge), arrivals[1]=1 once.
REQ-036 Pending spike at delay 3, enable held low 5 cycles, then enables -> arrival still exactly 3 enabled steps after sampling; valid only on enabled cycles.
REQ-037 Spikes pending, clear=1 with enable=1 -> valid=0, outputs 0, no later arrivals; repeat with reset=1 mid-stream -> all outputs 0 next clk.
